// File: rtl/vc_input_buffer_pkg.sv
// Shared defaults and helpers for the multi-VC input buffer.
package vc_input_buffer_pkg;

  localparam int unsigned FlitWidthDefault = 5;
  localparam int unsigned NumVcDefault     = 2;
  localparam int unsigned VcWDefault       = $clog2(NumVcDefault);

  typedef logic [VcWDefault-1:0] vc_id_t;

  // Width of a VC index; at least one bit even for a single channel.
  function automatic int unsigned vc_id_width(int unsigned num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  // LSB of VC 'vc' in the packed per-VC occupancy vector.
  function automatic int unsigned count_lsb(int unsigned vc, int unsigned cw);
    return vc * cw;
  endfunction

endpackage

// File: rtl/vc_input_buffer_if.sv
// Link-side write port, allocator-side read port and status of the VC input buffer.
interface vc_input_buffer_if #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned NUM_VC     = 2
);
  import vc_input_buffer_pkg::*;

  localparam int unsigned VC_W = vc_id_width(NUM_VC);
  localparam int unsigned CW   = DEPTH_LOG2 + 1;

  logic                   i_wr_en;
  logic [VC_W-1:0]        i_wr_vc;
  logic [WIDTH-1:0]       i_wr_data;
  logic                   i_rd_en;
  logic [VC_W-1:0]        i_rd_vc;
  logic                   i_err_clr;
  logic                   o_rd_valid;
  logic [WIDTH-1:0]       o_rd_data;
  logic [NUM_VC-1:0]      o_empty;
  logic [NUM_VC-1:0]      o_full;
  logic [NUM_VC-1:0]      o_afull;
  logic [NUM_VC*CW-1:0]   o_count;
  logic                   o_credit_vld;
  logic [VC_W-1:0]        o_credit_vc;
  logic                   o_ovf_err;
  logic                   o_udf_err;

  // Requester side: link receiver, allocator and error handling.
  modport master (
    output i_wr_en, i_wr_vc, i_wr_data, i_rd_en, i_rd_vc, i_err_clr,
    input  o_rd_valid, o_rd_data, o_empty, o_full, o_afull, o_count,
    input  o_credit_vld, o_credit_vc, o_ovf_err, o_udf_err
  );

  // Buffer side.
  modport slave (
    input  i_wr_en, i_wr_vc, i_wr_data, i_rd_en, i_rd_vc, i_err_clr,
    output o_rd_valid, o_rd_data, o_empty, o_full, o_afull, o_count,
    output o_credit_vld, o_credit_vc, o_ovf_err, o_udf_err
  );

endinterface

// File: rtl/vc_input_buffer_vc_fifo_ctrl.sv
// Pointer/flag controller for one VC's circular queue. Pointers carry an extra wrap bit.
module vc_input_buffer_vc_fifo_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned AF_THRESH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic [DEPTH_LOG2-1:0] wr_ptr_o,
  output logic [DEPTH_LOG2-1:0] rd_ptr_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  afull_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] AfThr = CW'(AF_THRESH);

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;

  // Advance pointers on accepted push/pop; wrap is natural modulo 2**CW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + CW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + CW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Status is derived purely from the registered pointers.
  always_comb begin
    count_o  = wr_ptr_q - rd_ptr_q;
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
               (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    afull_o  = (count_o >= AfThr);
    wr_ptr_o = wr_ptr_q[DEPTH_LOG2-1:0];
    rd_ptr_o = rd_ptr_q[DEPTH_LOG2-1:0];
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Multi-VC router input buffer: shared storage, registered read data, credits, sticky errors.
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter int unsigned WIDTH      = FlitWidthDefault,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned NUM_VC     = NumVcDefault,
  parameter int unsigned AF_THRESH  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  vc_input_buffer_if.slave    bus
);

  localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
  localparam int unsigned VC_W    = vc_id_width(NUM_VC);
  localparam int unsigned CW      = DEPTH_LOG2 + 1;
  localparam int unsigned VcSlots = 2 ** VC_W;
  localparam int unsigned AW      = VC_W + DEPTH_LOG2;

  logic [NUM_VC-1:0]     empty, full, afull, push, pop;
  logic [CW-1:0]         count [NUM_VC];
  logic [DEPTH_LOG2-1:0] wr_ptr [NUM_VC];
  logic [DEPTH_LOG2-1:0] rd_ptr [NUM_VC];
  logic [VcSlots-1:0]    vc_ok, full_x, empty_x;
  logic                  wr_ok, rd_ok, wr_rej, rd_rej;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [NUM_VC*CW-1:0]  count_flat;
  logic [WIDTH-1:0]      mem [NUM_VC*DEPTH];

  logic             rd_valid_q, credit_vld_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [VC_W-1:0]  credit_vc_q;
  logic             ovf_q, ovf_d, udf_q, udf_d;

  // Request decode. Out-of-range VC indices see a "not ok" slot and are rejected.
  always_comb begin
    vc_ok   = '0;
    vc_ok[NUM_VC-1:0] = '1;
    full_x  = '0;
    full_x[NUM_VC-1:0] = full;
    empty_x = '1;
    empty_x[NUM_VC-1:0] = empty;

    wr_ok  = bus.i_wr_en & vc_ok[bus.i_wr_vc] & ~full_x[bus.i_wr_vc];
    rd_ok  = bus.i_rd_en & vc_ok[bus.i_rd_vc] & ~empty_x[bus.i_rd_vc];
    wr_rej = bus.i_wr_en & ~wr_ok;
    rd_rej = bus.i_rd_en & ~rd_ok;

    push = '0;
    pop  = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      push[v] = wr_ok & (bus.i_wr_vc == VC_W'(v));
      pop[v]  = rd_ok & (bus.i_rd_vc == VC_W'(v));
    end

    wr_addr = '0;
    rd_addr = '0;
    if (wr_ok) wr_addr = {bus.i_wr_vc, wr_ptr[bus.i_wr_vc]};
    if (rd_ok) rd_addr = {bus.i_rd_vc, rd_ptr[bus.i_rd_vc]};

    // A new error in the same cycle as a clear keeps the flag set.
    ovf_d = wr_rej ? 1'b1 : (bus.i_err_clr ? 1'b0 : ovf_q);
    udf_d = rd_rej ? 1'b1 : (bus.i_err_clr ? 1'b0 : udf_q);
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_input_buffer_vc_fifo_ctrl #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .AF_THRESH  (AF_THRESH)
    ) u_ctrl (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .push_i   (push[v]),
      .pop_i    (pop[v]),
      .wr_ptr_o (wr_ptr[v]),
      .rd_ptr_o (rd_ptr[v]),
      .empty_o  (empty[v]),
      .full_o   (full[v]),
      .afull_o  (afull[v]),
      .count_o  (count[v])
    );
  end

  // Shared flit storage; not reset, contents are only meaningful between pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= bus.i_wr_data;
  end

  // Registered read data, credit return and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      credit_vld_q <= 1'b0;
      credit_vc_q  <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      rd_valid_q   <= rd_ok;
      credit_vld_q <= rd_ok;
      if (rd_ok) begin
        rd_data_q   <= mem[rd_addr];
        credit_vc_q <= bus.i_rd_vc;
      end
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Pack per-VC occupancy.
  always_comb begin
    count_flat = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      count_flat[count_lsb(v, CW) +: CW] = count[v];
    end
  end

  assign bus.o_rd_valid   = rd_valid_q;
  assign bus.o_rd_data    = rd_data_q;
  assign bus.o_empty      = empty;
  assign bus.o_full       = full;
  assign bus.o_afull      = afull;
  assign bus.o_count      = count_flat;
  assign bus.o_credit_vld = credit_vld_q;
  assign bus.o_credit_vc  = credit_vc_q;
  assign bus.o_ovf_err    = ovf_q;
  assign bus.o_udf_err    = udf_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Randomised + directed bench for vc_input_buffer with a queue-based reference model.
module tb_vc_input_buffer;

  localparam int unsigned WIDTH      = 5;
  localparam int unsigned DEPTH_LOG2 = 2;
  localparam int unsigned NUM_VC     = 2;
  localparam int unsigned AF_THRESH  = 3;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned VC_W       = 1;
  localparam int unsigned CW         = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [VC_W-1:0]  vc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vc_input_buffer_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .NUM_VC(NUM_VC)) bif ();

  vc_input_buffer #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .NUM_VC     (NUM_VC),
    .AF_THRESH  (AF_THRESH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // Reference model: one FIFO queue per VC plus sticky flags.
  logic [WIDTH-1:0] mq [NUM_VC][$];
  exp_t             sb [$];
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;
  logic             mon_en = 1'b0;
  logic [WIDTH-1:0] last_data = '0;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; model advances at the clock edge the DUT samples.
  task automatic step(input bit we, input int wvc, input logic [WIDTH-1:0] wd,
                      input bit re, input int rvc, input bit clr);
    bit   wok, rok;
    exp_t e;
    bif.i_wr_en   = we;
    bif.i_wr_vc   = VC_W'(wvc);
    bif.i_wr_data = wd;
    bif.i_rd_en   = re;
    bif.i_rd_vc   = VC_W'(rvc);
    bif.i_err_clr = clr;
    wok = we && (wvc < NUM_VC) && (mq[wvc].size() < DEPTH);
    rok = re && (rvc < NUM_VC) && (mq[rvc].size() > 0);
    @(posedge clk);
    if (rok) begin
      e.d  = mq[rvc].pop_front();
      e.vc = VC_W'(rvc);
      sb.push_back(e);
    end
    if (wok) mq[wvc].push_back(wd);
    m_ovf = (we && !wok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf = (re && !rok) ? 1'b1 : (clr ? 1'b0 : m_udf);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  // Monitor: consumes the scoreboard when the DUT presents data; checks status every cycle.
  always @(negedge clk) begin
    exp_t e;
    int   sz;
    if (!rst_n) begin
      last_data = '0;
    end else if (mon_en) begin
      if (bif.o_rd_valid) begin
        if (sb.size() == 0) begin
          chk("rd_valid_unexpected", 32'(bif.o_rd_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("rd_data", 32'(bif.o_rd_data), 32'(e.d));
          chk("credit_vld", 32'(bif.o_credit_vld), 32'(1));
          chk("credit_vc", 32'(bif.o_credit_vc), 32'(e.vc));
          last_data = e.d;
        end
      end else begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rd_valid_missing", 32'(bif.o_rd_valid), 32'(1));
        end
        chk("credit_idle", 32'(bif.o_credit_vld), 32'(0));
        chk("rd_data_hold", 32'(bif.o_rd_data), 32'(last_data));
      end
      for (int v = 0; v < NUM_VC; v++) begin
        sz = mq[v].size();
        chk($sformatf("count%0d", v), 32'(bif.o_count[v*CW +: CW]), 32'(sz));
        chk($sformatf("empty%0d", v), 32'(bif.o_empty[v]), 32'(sz == 0));
        chk($sformatf("full%0d", v), 32'(bif.o_full[v]), 32'(sz == DEPTH));
        chk($sformatf("afull%0d", v), 32'(bif.o_afull[v]), 32'(sz >= AF_THRESH));
      end
      chk("ovf_err", 32'(bif.o_ovf_err), 32'(m_ovf));
      chk("udf_err", 32'(bif.o_udf_err), 32'(m_udf));
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(bif.o_empty), 32'(2'b11));
    chk({tag, "_full"}, 32'(bif.o_full), 32'(0));
    chk({tag, "_afull"}, 32'(bif.o_afull), 32'(0));
    chk({tag, "_count"}, 32'(bif.o_count), 32'(0));
    chk({tag, "_rd_valid"}, 32'(bif.o_rd_valid), 32'(0));
    chk({tag, "_rd_data"}, 32'(bif.o_rd_data), 32'(0));
    chk({tag, "_credit_vld"}, 32'(bif.o_credit_vld), 32'(0));
    chk({tag, "_credit_vc"}, 32'(bif.o_credit_vc), 32'(0));
    chk({tag, "_ovf"}, 32'(bif.o_ovf_err), 32'(0));
    chk({tag, "_udf"}, 32'(bif.o_udf_err), 32'(0));
  endtask

  initial begin
    logic [31:0] r;
    bit we, re;
    bif.i_wr_en = 1'b0; bif.i_wr_vc = '0; bif.i_wr_data = '0;
    bif.i_rd_en = 1'b0; bif.i_rd_vc = '0; bif.i_err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Fill VC0, then one write too many.
    for (int i = 1; i <= 4; i++) step(1'b1, 0, WIDTH'(i), 1'b0, 0, 1'b0);
    step(1'b1, 0, 5'h05, 1'b0, 0, 1'b0);
    // Drain VC0 in order.
    for (int i = 0; i < 4; i++) step(1'b0, 0, '0, 1'b1, 0, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, 1'b1);
    idle();

    // Interleaved VCs.
    step(1'b1, 1, 5'h1A, 1'b0, 0, 1'b0);
    step(1'b1, 0, 5'h0A, 1'b0, 0, 1'b0);
    step(1'b1, 1, 5'h1B, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 1, 1'b0);
    step(1'b0, 0, '0, 1'b1, 1, 1'b0);

    // Full VC0 with simultaneous write and read of VC0.
    step(1'b1, 0, 5'h0B, 1'b0, 0, 1'b0);
    step(1'b1, 0, 5'h0C, 1'b0, 0, 1'b0);
    step(1'b1, 0, 5'h0D, 1'b0, 0, 1'b0);
    step(1'b1, 0, 5'h1F, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, '0, 1'b1, 0, 1'b0);

    // Underflow, clear, then clear racing a new error.
    step(1'b0, 0, '0, 1'b1, 1, 1'b1);
    step(1'b0, 0, '0, 1'b0, 0, 1'b1);
    step(1'b0, 0, '0, 1'b1, 1, 1'b0);
    step(1'b0, 0, '0, 1'b1, 1, 1'b1);
    step(1'b0, 0, '0, 1'b0, 0, 1'b1);

    // Pointer wrap on VC1: write/read pairs, then overlapped write+read.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1, WIDTH'(i + 3), 1'b0, 0, 1'b0);
      step(1'b0, 0, '0, 1'b1, 1, 1'b0);
    end
    step(1'b1, 1, 5'h11, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1, WIDTH'(i + 20), 1'b1, 1, 1'b0);
    idle();

    // Asynchronous reset mid-stream with two flits in VC0.
    step(1'b1, 0, 5'h07, 1'b0, 0, 1'b0);
    step(1'b1, 0, 5'h08, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_empty", 32'(bif.o_empty), 32'(2'b11));
    chk("midrst_rd_valid", 32'(bif.o_rd_valid), 32'(0));
    chk("midrst_count0", 32'(bif.o_count[CW-1:0]), 32'(0));
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic: write-heavy then read-heavy to reach both full and empty.
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom;
      if (n < 1500) begin
        we = r[0] | r[1];
        re = r[8] & r[9];
      end else begin
        we = r[0] & r[1];
        re = r[8] | r[9];
      end
      step(we, int'(r[3]), r[7:3], re, int'(r[11]), r[15:12] == 4'd0);
    end
    idle();
    idle();
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
